digit_scheduler: RTL and testbench

Sequences reads of the 21×230 black-and-white numbers ROM (digits 0–9 stacked vertically, 23 rows each) so that a multi-digit BCD value is drawn at a fixed screen position. It sits between the VGA timing generator and the numbers ROM. It converts the live pixel coordinate into ROM x/y addresses, aligns the ROM's one-cycle read latency with pixel validity, and accepts new values through a ready/valid handshake that commits only at frame start, so digits never tear mid-frame.

---
 rtl/digit_scheduler_if.sv | 30 +++
 rtl/digit_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_digit_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_scheduler_if.sv
// Pixel, value-handshake and ROM signals shared between the VGA timing side,
// the numbers ROM and digit_scheduler.
interface digit_scheduler_if #(
  parameter int DIGITS = 4
) ();
  logic [9:0]          px_x;
  logic [9:0]          px_y;
  logic                px_valid;
  logic                frame_start;
  logic [4*DIGITS-1:0] value;
  logic                value_valid;
  logic                value_ready;
  logic [9:0]          x_rom;
  logic [9:0]          y_rom;
  logic                rom_pixel;
  logic                pixel_out;
  logic                pixel_valid;

  // Environment side: timing generator, value producer and ROM data.
  modport master (
    output px_x, px_y, px_valid, frame_start, value, value_valid, rom_pixel,
    input  value_ready, x_rom, y_rom, pixel_out, pixel_valid
  );

  // Scheduler side.
  modport slave (
    input  px_x, px_y, px_valid, frame_start, value, value_valid, rom_pixel,
    output value_ready, x_rom, y_rom, pixel_out, pixel_valid
  );
endinterface

// File: rtl/digit_scheduler.sv
// digit_scheduler: turns the live pixel coordinate into numbers-ROM x/y
// addresses so a multi-digit BCD value is drawn at a fixed screen position.
// New values are taken over a ready/valid handshake but only become visible
// at frame start, so a digit never changes in the middle of a frame.
module digit_scheduler #(
  parameter int DIGITS   = 4,
  parameter int X0       = 200,
  parameter int Y0       = 100,
  parameter int DIGIT_W  = 21,
  parameter int DIGIT_H  = 23,
  parameter int GAP      = 3,
  parameter int LZ_BLANK = 1
) (
  input  logic         clk,
  input  logic         rstn,
  digit_scheduler_if.slave bus
);

  localparam int DIG_BITS = $clog2(DIGITS + 1);
  localparam int COL_BITS = $clog2(DIGIT_W + GAP);
  localparam int VW       = 4 * DIGITS;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(DIGIT_W + GAP - 1);
  localparam logic [COL_BITS-1:0] COL_W    = COL_BITS'(DIGIT_W);
  localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
  localparam logic [DIG_BITS-1:0] DIG_END  = DIG_BITS'(DIGITS);
  localparam logic [DIG_BITS-1:0] DIG_LAST = DIG_BITS'(DIGITS - 1);
  localparam logic [DIG_BITS-1:0] DIG_ONE  = DIG_BITS'(1);
  localparam logic [9:0]          X0_C     = 10'(X0);
  localparam logic [9:0]          Y0_C     = 10'(Y0);
  localparam logic [9:0]          H_C      = 10'(DIGIT_H);
  localparam logic [9:0]          ADDR_OFF = 10'h3FF;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [VW-1:0]       pending_q, pending_d;
  logic [VW-1:0]       active_q, active_d;

  // col_q/dig_q hold the position the next valid pixel will occupy; the
  // *_cur_s values are the position of the pixel presented this cycle.
  logic [COL_BITS-1:0] col_q, col_d, col_cur_s;
  logic [DIG_BITS-1:0] dig_q, dig_d, dig_cur_s;

  logic [9:0]          row_s;
  logic                in_win_s;
  logic [3:0]          nib_s;
  logic                lz_s;
  logic                blank_s;
  logic                en_s;

  logic [9:0]          x_rom_q, x_rom_d;
  logic [9:0]          y_rom_q, y_rom_d;
  logic                en_a_q;   // address-stage enable, aligned with x_rom/y_rom
  logic                v_a_q;    // px_valid aligned with x_rom/y_rom
  logic                en_b_q;   // enable aligned with rom_pixel
  logic                v_b_q;    // px_valid aligned with rom_pixel
  logic                pix_q;
  logic                pv_q;

  // Value handshake: accept into pending while idle, commit at frame start.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    case (state_q)
      S_IDLE: begin
        if (bus.value_valid && ready_q) begin
          pending_d = bus.value;
          state_d   = S_PENDING;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_PENDING: begin
        if (bus.frame_start) begin
          active_d = pending_q;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_PENDING;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Handshake state, pending and active value registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  // Column/digit position of the current pixel and of the next one.
  always_comb begin
    if (bus.px_valid && (bus.px_x == X0_C)) begin
      col_cur_s = '0;
      dig_cur_s = '0;
    end else begin
      col_cur_s = col_q;
      dig_cur_s = dig_q;
    end
    col_d = col_q;
    dig_d = dig_q;
    if (bus.px_valid) begin
      if (col_cur_s == COL_LAST) begin
        col_d = '0;
        dig_d = (dig_cur_s == DIG_END) ? DIG_END : (dig_cur_s + DIG_ONE);
      end else begin
        col_d = col_cur_s + COL_ONE;
        dig_d = dig_cur_s;
      end
    end else begin
      col_d = col_q;
      dig_d = dig_q;
    end
  end

  // Column/digit counters; dig parks at DIGITS past the last digit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      dig_q <= DIG_END;
    end else begin
      col_q <= col_d;
      dig_q <= dig_d;
    end
  end

  // Window test, digit nibble selection, blanking and ROM address.
  always_comb begin
    row_s    = bus.px_y - Y0_C;
    in_win_s = bus.px_valid && (bus.px_x >= X0_C) && (bus.px_y >= Y0_C) &&
               (dig_cur_s < DIG_END) && (col_cur_s < COL_W) && (row_s < H_C);
    nib_s    = 4'h0;
    lz_s     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib_s = (dig_cur_s == DIG_BITS'(i)) ? active_q[4*(DIGITS-1-i) +: 4] : nib_s;
      lz_s  = ((DIG_BITS'(i) <= dig_cur_s) && (active_q[4*(DIGITS-1-i) +: 4] != 4'h0))
              ? 1'b0 : lz_s;
    end
    blank_s = (nib_s > 4'd9) ||
              ((LZ_BLANK != 0) && lz_s && (dig_cur_s != DIG_LAST));
    en_s    = in_win_s && !blank_s;
    if (en_s) begin
      x_rom_d = 10'(col_cur_s);
      y_rom_d = (10'(nib_s) * H_C) + row_s;
    end else begin
      x_rom_d = ADDR_OFF;
      y_rom_d = ADDR_OFF;
    end
  end

  // Address stage, ROM-latency alignment and output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_rom_q <= ADDR_OFF;
      y_rom_q <= ADDR_OFF;
      en_a_q  <= 1'b0;
      v_a_q   <= 1'b0;
      en_b_q  <= 1'b0;
      v_b_q   <= 1'b0;
      pix_q   <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      x_rom_q <= x_rom_d;
      y_rom_q <= y_rom_d;
      en_a_q  <= en_s;
      v_a_q   <= bus.px_valid;
      en_b_q  <= en_a_q;
      v_b_q   <= v_a_q;
      pix_q   <= bus.rom_pixel && en_b_q;
      pv_q    <= v_b_q;
    end
  end

  assign bus.value_ready = ready_q;
  assign bus.x_rom       = x_rom_q;
  assign bus.y_rom       = y_rom_q;
  assign bus.pixel_out   = pix_q;
  assign bus.pixel_valid = pv_q;

endmodule

// File: tb/tb_digit_scheduler.sv
// Self-checking bench for digit_scheduler: directed table of address checks,
// handshake/latency/reset sequences, then randomized line scans against a
// coordinate-arithmetic reference model.
module tb_digit_scheduler;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rom_all_ones = 1'b0;

  int checks = 0;
  int errors = 0;

  digit_scheduler_if #(.DIGITS(4)) bus ();

  digit_scheduler dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Numbers ROM content stand-in: anything outside 21x230 reads as 0.
  function automatic logic rom_bit(input logic [9:0] xa, input logic [9:0] ya);
    if (xa < 10'd21 && ya < 10'd230) begin
      if (rom_all_ones) return 1'b1;
      return ((int'(xa) * 3 + int'(ya) * 5) % 7) < 3;
    end
    return 1'b0;
  endfunction

  // ROM with one cycle of read latency.
  always @(posedge clk) bus.rom_pixel <= rom_bit(bus.x_rom, bus.y_rom);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scan a line contiguously from x=190 up to xt and check the address
  // produced for the pixel at xt.
  task automatic sweep(input string nm, input int y, input int xt, input int ex, input int ey);
    bus.px_valid = 1'b0;
    step();
    for (int x = 190; x <= xt; x++) begin
      bus.px_x = 10'(x);
      bus.px_y = 10'(y);
      bus.px_valid = 1'b1;
      step();
    end
    chk({nm, " x_rom"}, int'(bus.x_rom), ex);
    chk({nm, " y_rom"}, int'(bus.y_rom), ey);
    bus.px_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic offer(input logic [15:0] v);
    bus.value = v;
    bus.value_valid = 1'b1;
    step();
    bus.value_valid = 1'b0;
  endtask

  // Reference: what a given pixel sample should address, from screen geometry.
  task automatic model_addr(input logic pv, input int x, input int y, input logic [15:0] act,
                            output logic en, output int xa, output int ya);
    int rel, d, c, row;
    logic [3:0] n;
    logic lz;
    en = 1'b0;
    xa = 'h3FF;
    ya = 'h3FF;
    if (pv && x >= 200 && y >= 100 && (y - 100) < 23) begin
      rel = x - 200;
      d   = rel / 24;
      c   = rel % 24;
      row = y - 100;
      if (d < 4 && c < 21) begin
        n  = act[15 - 4*d -: 4];
        lz = 1'b1;
        for (int k = 0; k <= d; k++) if (act[15 - 4*k -: 4] != 4'h0) lz = 1'b0;
        if (n <= 4'd9 && !(lz && d != 3)) begin
          en = 1'b1;
          xa = c;
          ya = int'(n) * 23 + row;
        end
      end
    end
  endtask

  typedef struct {
    string nm;
    int    y;
    int    x;
    int    ex;
    int    ey;
  } vec_t;

  vec_t tbl[12];

  logic [15:0] m_active, m_pending;
  logic        m_has_pend;
  logic        q_pix[$];
  logic        q_pv[$];

  initial begin
    tbl[0]  = '{"digit1 col5 row7", 107, 229, 5,     53};
    tbl[1]  = '{"first gap col",    107, 221, 'h3FF, 'h3FF};
    tbl[2]  = '{"x0 first col",     107, 200, 0,     30};
    tbl[3]  = '{"top row",          100, 203, 3,     23};
    tbl[4]  = '{"last row",         122, 250, 2,     91};
    tbl[5]  = '{"row below",        123, 250, 'h3FF, 'h3FF};
    tbl[6]  = '{"row above",         99, 250, 'h3FF, 'h3FF};
    tbl[7]  = '{"last digit col20", 110, 292, 20,    102};
    tbl[8]  = '{"last digit col21", 110, 293, 'h3FF, 'h3FF};
    tbl[9]  = '{"dig saturated",    110, 296, 'h3FF, 'h3FF};
    tbl[10] = '{"far right no wrap",110, 330, 'h3FF, 'h3FF};
    tbl[11] = '{"left of x0",       110, 199, 'h3FF, 'h3FF};

    bus.px_x = 10'd0;
    bus.px_y = 10'd0;
    bus.px_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.value = 16'h0000;
    bus.value_valid = 1'b0;

    // Reset values.
    step();
    step();
    chk("reset x_rom", int'(bus.x_rom), 'h3FF);
    chk("reset y_rom", int'(bus.y_rom), 'h3FF);
    chk("reset pixel_out", int'(bus.pixel_out), 0);
    chk("reset pixel_valid", int'(bus.pixel_valid), 0);
    chk("reset value_ready", int'(bus.value_ready), 1);
    rstn = 1'b1;
    step();

    // Commit 1234 and run the address table.
    offer(16'h1234);
    pulse_fs();
    chk("ready after commit", int'(bus.value_ready), 1);
    foreach (tbl[i]) sweep(tbl[i].nm, tbl[i].y, tbl[i].x, tbl[i].ex, tbl[i].ey);

    // Latency: a single valid pixel at X0 appears at pixel_out three edges later.
    rom_all_ones = 1'b1;
    bus.px_valid = 1'b0;
    step();
    step();
    step();
    bus.px_x = 10'd200;
    bus.px_y = 10'd107;
    bus.px_valid = 1'b1;
    step();
    bus.px_valid = 1'b0;
    chk("lat t+1 x_rom", int'(bus.x_rom), 0);
    chk("lat t+1 pixel_valid", int'(bus.pixel_valid), 0);
    chk("lat t+1 pixel_out", int'(bus.pixel_out), 0);
    step();
    chk("lat t+2 pixel_valid", int'(bus.pixel_valid), 0);
    chk("lat t+2 pixel_out", int'(bus.pixel_out), 0);
    step();
    chk("lat t+3 pixel_valid", int'(bus.pixel_valid), 1);
    chk("lat t+3 pixel_out", int'(bus.pixel_out), 1);
    step();
    chk("lat t+4 pixel_valid", int'(bus.pixel_valid), 0);
    chk("lat t+4 pixel_out", int'(bus.pixel_out), 0);
    rom_all_ones = 1'b0;

    // Handshake: accept 0042, reject 9999 while busy, commit at frame start.
    offer(16'h0042);
    chk("hs ready low", int'(bus.value_ready), 0);
    offer(16'h9999);
    chk("hs ready still low", int'(bus.value_ready), 0);
    sweep("hs before commit", 107, 229, 5, 53);
    pulse_fs();
    chk("hs ready back", int'(bus.value_ready), 1);
    sweep("lz digit0", 107, 205, 'h3FF, 'h3FF);
    sweep("lz digit1", 107, 229, 'h3FF, 'h3FF);
    sweep("digit2 four", 107, 253, 5, 99);
    sweep("digit3 two", 107, 280, 8, 53);

    // Accept and frame_start in the same idle cycle: commit one frame later.
    bus.value = 16'h0A05;
    bus.value_valid = 1'b1;
    bus.frame_start = 1'b1;
    step();
    bus.value_valid = 1'b0;
    bus.frame_start = 1'b0;
    chk("simul ready low", int'(bus.value_ready), 0);
    sweep("simul old value", 107, 253, 5, 99);
    pulse_fs();
    chk("simul ready back", int'(bus.value_ready), 1);
    sweep("nibble A blank", 107, 229, 'h3FF, 'h3FF);
    sweep("zero after A shown", 107, 253, 5, 7);
    sweep("digit3 five", 107, 280, 8, 122);

    // Reset in the middle of a line with a value pending.
    offer(16'h7777);
    bus.px_valid = 1'b0;
    step();
    for (int x = 190; x <= 230; x++) begin
      bus.px_x = 10'(x);
      bus.px_y = 10'd107;
      bus.px_valid = 1'b1;
      step();
    end
    rstn = 1'b0;
    #1;
    chk("midreset x_rom", int'(bus.x_rom), 'h3FF);
    chk("midreset y_rom", int'(bus.y_rom), 'h3FF);
    chk("midreset pixel_out", int'(bus.pixel_out), 0);
    chk("midreset pixel_valid", int'(bus.pixel_valid), 0);
    chk("midreset value_ready", int'(bus.value_ready), 1);
    bus.px_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    pulse_fs();
    sweep("pending discarded", 107, 276, 4, 7);

    // Randomized line scans against the reference model.
    m_active   = 16'h0000;
    m_pending  = 16'h0000;
    m_has_pend = 1'b0;
    q_pix.delete();
    q_pv.delete();
    bus.px_valid = 1'b0;
    step();
    for (int line = 0; line < 24; line++) begin
      int x, y, xend;
      x    = $urandom_range(185, 199);
      y    = $urandom_range(95, 126);
      xend = $urandom_range(290, 320);
      for (int cyc = 0; cyc < 400 && x <= xend; cyc++) begin
        logic pv, fs, vv, en;
        logic [15:0] val;
        int xa, ya;
        pv  = ($urandom_range(0, 4) != 0);
        fs  = ($urandom_range(0, 39) == 0);
        vv  = ($urandom_range(0, 9) == 0);
        val = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
        model_addr(pv, x, y, m_active, en, xa, ya);
        q_pix.push_back(en && rom_bit(10'(xa), 10'(ya)));
        q_pv.push_back(pv);
        if (!m_has_pend && vv) begin
          m_pending  = val;
          m_has_pend = 1'b1;
        end else if (m_has_pend && fs) begin
          m_active   = m_pending;
          m_has_pend = 1'b0;
        end
        bus.px_x        = 10'(x);
        bus.px_y        = 10'(y);
        bus.px_valid    = pv;
        bus.frame_start = fs;
        bus.value_valid = vv;
        bus.value       = val;
        step();
        chk("rand x_rom", int'(bus.x_rom), xa);
        chk("rand y_rom", int'(bus.y_rom), ya);
        chk("rand value_ready", int'(bus.value_ready), int'(!m_has_pend));
        if (q_pix.size() >= 3) begin
          chk("rand pixel_out", int'(bus.pixel_out), int'(q_pix[q_pix.size() - 3]));
          chk("rand pixel_valid", int'(bus.pixel_valid), int'(q_pv[q_pv.size() - 3]));
        end
        if (pv) x++;
      end
      bus.frame_start = 1'b0;
      bus.value_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
